tetris_board: RTL and testbench



---
 rtl/tetris_lock_if.sv | 21 ++
 rtl/tetris_board.sv | 136 +++++++++++++
 tb/tb_tetris_board.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_lock_if.sv
// Lock request channel: a landed piece's four cell indices with a valid/ready handshake.
interface tetris_lock_if #(
  parameter int unsigned POS_W = 8
);
  logic             lock_valid;
  logic             lock_ready;
  logic [POS_W-1:0] lock_blk_1;
  logic [POS_W-1:0] lock_blk_2;
  logic [POS_W-1:0] lock_blk_3;
  logic [POS_W-1:0] lock_blk_4;

  modport master (
    output lock_valid, lock_blk_1, lock_blk_2, lock_blk_3, lock_blk_4,
    input  lock_ready
  );

  modport slave (
    input  lock_valid, lock_blk_1, lock_blk_2, lock_blk_3, lock_blk_4,
    output lock_ready
  );
endinterface

// File: rtl/tetris_board.sv
// Playfield occupancy map: merges locked pieces, removes complete rows by shifting
// the rows above them down, and keeps per-lock and running line counts.
module tetris_board #(
  parameter int unsigned BLOCKS_WIDE = 10,
  parameter int unsigned BLOCKS_HIGH = 20,
  parameter int unsigned POS_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  tetris_lock_if.slave                       lock_if,
  input  logic                               clear_board_i,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [2:0]                         lines_cleared_o,
  output logic [15:0]                        total_lines_o
);

  localparam int unsigned CELLS = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int unsigned ROW_W = $clog2(BLOCKS_HIGH);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned TOT_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_MERGE, S_SCAN, S_SHIFT, S_DONE} state_e;

  state_e           state_q;
  logic [CELLS-1:0] board_q;
  logic [ROW_W-1:0] row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic [CNT_W-1:0] lines_q;
  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] total_d;
  logic [TOT_W:0]   total_sum;
  logic [POS_W-1:0] blk_q [4];
  int unsigned      row_base_c;
  logic             row_full_c;

  assign lock_if.lock_ready = (state_q == S_IDLE) && !clear_board_i;
  assign busy_o             = (state_q != S_IDLE);

  assign fallen_pieces_o = board_q;
  assign done_o          = done_q;
  assign lines_cleared_o = lines_q;
  assign total_lines_o   = total_q;

  assign row_base_c = 32'(row_q) * BLOCKS_WIDE;
  assign row_full_c = &board_q[row_base_c +: BLOCKS_WIDE];

  // Per-lock count saturates at 7; running total saturates at 65535.
  assign cnt_d     = (cnt_q == '1) ? cnt_q : CNT_W'(cnt_q + CNT_W'(1));
  assign total_sum = (TOT_W+1)'(total_q) + (TOT_W+1)'(cnt_q);
  assign total_d   = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];

  function automatic logic [CELLS-1:0] merge_cells(input logic [CELLS-1:0] b);
    logic [CELLS-1:0] n;
    n = b;
    for (int i = 0; i < 4; i++) begin
      if (32'(blk_q[i]) < CELLS) n[blk_q[i]] = 1'b1;
    end
    return n;
  endfunction

  // Rows 1..r take the row above; row 0 empties; rows below r are untouched.
  function automatic logic [CELLS-1:0] shift_down(input logic [CELLS-1:0] b,
                                                  input logic [ROW_W-1:0] r);
    logic [CELLS-1:0] n;
    n = b;
    for (int unsigned y = 0; y < BLOCKS_HIGH; y++) begin
      if (y <= 32'(r)) begin
        if (y == 0) n[0 +: BLOCKS_WIDE] = '0;
        else        n[y*BLOCKS_WIDE +: BLOCKS_WIDE] = b[(y-1)*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      board_q <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      lines_q <= '0;
      total_q <= '0;
      for (int i = 0; i < 4; i++) blk_q[i] <= '0;
    end else if (clear_board_i) begin
      state_q <= S_IDLE;
      board_q <= '0;
      done_q  <= 1'b0;
      lines_q <= '0;
      total_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (lock_if.lock_valid) begin
            blk_q[0] <= lock_if.lock_blk_1;
            blk_q[1] <= lock_if.lock_blk_2;
            blk_q[2] <= lock_if.lock_blk_3;
            blk_q[3] <= lock_if.lock_blk_4;
            row_q    <= ROW_W'(BLOCKS_HIGH - 1);
            cnt_q    <= '0;
            state_q  <= S_MERGE;
          end
        end
        S_MERGE: begin
          board_q <= merge_cells(board_q);
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (row_full_c) begin
            cnt_q   <= cnt_d;
            state_q <= S_SHIFT;
          end else if (row_q == '0) begin
            done_q  <= 1'b1;
            lines_q <= cnt_q;
            total_q <= total_d;
            state_q <= S_DONE;
          end else begin
            row_q <= row_q - ROW_W'(1);
          end
        end
        S_SHIFT: begin
          board_q <= shift_down(board_q, row_q);
          state_q <= S_SCAN;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_board.sv
// Directed bench for tetris_board: reset, merge, single and quad line clears,
// clear_board priority, held requests while busy, and mid-operation reset.
module tb_tetris_board;
  localparam int unsigned W     = 10;
  localparam int unsigned H     = 20;
  localparam int unsigned CELLS = W * H;
  localparam int unsigned PW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_board;
  logic [CELLS-1:0] fallen;
  logic busy, done;
  logic [2:0] lines;
  logic [15:0] total;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tetris_lock_if #(.POS_W(PW)) lock_if ();

  tetris_board #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .POS_W(PW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lock_if         (lock_if),
    .clear_board_i   (clear_board),
    .fallen_pieces_o (fallen),
    .busy_o          (busy),
    .done_o          (done),
    .lines_cleared_o (lines),
    .total_lines_o   (total)
  );

  function automatic logic [CELLS-1:0] cells4(input int a, input int b, input int c, input int d);
    logic [CELLS-1:0] v;
    v = '0;
    v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1; v[d] = 1'b1;
    return v;
  endfunction

  task automatic drive_lock(input int a, input int b, input int c, input int d);
    lock_if.lock_blk_1 = PW'(a);
    lock_if.lock_blk_2 = PW'(b);
    lock_if.lock_blk_3 = PW'(c);
    lock_if.lock_blk_4 = PW'(d);
    lock_if.lock_valid = 1'b1;
  endtask

  // One lock end to end; cycle n is the n-th cycle after the transfer edge.
  task automatic do_lock(input string name, input int a, input int b, input int c, input int d,
                         input bit chk_board, input logic [CELLS-1:0] exp_merge,
                         input logic [CELLS-1:0] exp_final, input int exp_done,
                         input logic [2:0] exp_lines, input logic [15:0] exp_total);
    int done_cyc;
    done_cyc = 0;
    @(negedge clk);
    drive_lock(a, b, c, d);
    checks++;
    if (lock_if.lock_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_at_transfer got=%b want=1", name, lock_if.lock_ready);
    end
    @(posedge clk); #1 lock_if.lock_valid = 1'b0;
    for (int n = 1; n <= 60 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (n == 2 && chk_board) begin
        checks++;
        if (fallen !== exp_merge) begin
          failures++; $display("FAIL %s merge got=%h want=%h", name, fallen, exp_merge);
        end
      end
      if (done === 1'b1) done_cyc = n;
    end
    checks++;
    if (done_cyc != exp_done) begin
      failures++; $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, exp_done);
    end
    checks++;
    if (lines !== exp_lines) begin
      failures++; $display("FAIL %s lines_cleared got=%0d want=%0d", name, lines, exp_lines);
    end
    checks++;
    if (total !== exp_total) begin
      failures++; $display("FAIL %s total_lines got=%0d want=%0d", name, total, exp_total);
    end
    @(negedge clk);
    checks++;
    if (lock_if.lock_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL %s after_done ready=%b busy=%b done=%b want 1/0/0",
                           name, lock_if.lock_ready, busy, done);
    end
    if (chk_board) begin
      checks++;
      if (fallen !== exp_final) begin
        failures++; $display("FAIL %s final_board got=%h want=%h", name, fallen, exp_final);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (fallen !== '0 || lock_if.lock_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        lines !== 3'd0 || total !== 16'd0) begin
      failures++; $display("FAIL reset_values fp=%h rdy=%b busy=%b done=%b lines=%0d total=%0d",
                           fallen, lock_if.lock_ready, busy, done, lines, total);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (fallen !== '0 || lock_if.lock_ready !== 1'b1 || busy !== 1'b0 || total !== 16'd0) begin
        failures++; $display("FAIL reset_hold cycle=%0d fp=%h rdy=%b busy=%b total=%0d",
                             i, fallen, lock_if.lock_ready, busy, total);
      end
    end
  endtask

  task automatic test_single_lock;
    logic [CELLS-1:0] b;
    b = cells4(190, 191, 192, 193);
    do_lock("single", 190, 191, 192, 193, 1'b1, b, b, 22, 3'd0, 16'd0);
  endtask

  task automatic test_line_clear;
    logic [CELLS-1:0] b1, b2, fin;
    b1 = cells4(190, 191, 192, 193) | cells4(194, 195, 180, 181);
    do_lock("pre_row19", 194, 195, 180, 181, 1'b1, b1, b1, 22, 3'd0, 16'd0);
    b2  = b1 | cells4(196, 197, 198, 199);
    fin = cells4(190, 191, 190, 191);
    do_lock("one_line", 196, 197, 198, 199, 1'b1, b2, fin, 24, 3'd1, 16'd1);
  endtask

  task automatic test_tetris;
    logic [CELLS-1:0] pre;
    pre = '0;
    for (int y = 16; y < 20; y++) begin
      do_lock("preload_a", y*10, y*10+1, y*10+2, y*10+3, 1'b0, '0, '0, 22, 3'd0, 16'd1);
      do_lock("preload_b", y*10+4, y*10+5, y*10+6, y*10+7, 1'b0, '0, '0, 22, 3'd0, 16'd1);
      for (int x = 0; x < 9; x++) pre[y*10+x] = 1'b1;
    end
    do_lock("preload_c", 168, 178, 188, 198, 1'b0, '0, '0, 22, 3'd0, 16'd1);
    checks++;
    if (fallen !== pre) begin
      failures++; $display("FAIL preload_board got=%h want=%h", fallen, pre);
    end
    do_lock("tetris", 169, 179, 189, 199, 1'b1, pre | cells4(169, 179, 189, 199), '0,
            30, 3'd4, 16'd5);
  endtask

  task automatic test_clear_board;
    int bad;
    @(negedge clk);
    drive_lock(0, 1, 2, 3);
    @(posedge clk); #1 lock_if.lock_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fallen !== cells4(0, 1, 2, 3)) begin
      failures++; $display("FAIL clr_scan_state busy=%b fp=%h", busy, fallen);
    end
    clear_board = 1'b1;
    drive_lock(10, 11, 12, 13);
    @(posedge clk); #1 clear_board = 1'b0; lock_if.lock_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fallen !== '0 || total !== 16'd0 || lines !== 3'd0 || busy !== 1'b0 ||
        lock_if.lock_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL clr_after fp=%h total=%0d lines=%0d busy=%b rdy=%b done=%b",
                           fallen, total, lines, busy, lock_if.lock_ready, done);
    end
    // In IDLE a lock presented together with clear must be refused.
    clear_board = 1'b1;
    drive_lock(20, 21, 22, 23);
    #1;
    checks++;
    if (lock_if.lock_ready !== 1'b0) begin
      failures++; $display("FAIL clr_idle_ready got=%b want=0", lock_if.lock_ready);
    end
    @(posedge clk); #1 clear_board = 1'b0; lock_if.lock_valid = 1'b0;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || fallen !== '0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL clr_quiet bad_cycles=%0d want=0", bad);
    end
  endtask

  task automatic test_busy_hold;
    logic [CELLS-1:0] first, second;
    int done_cyc;
    first  = cells4(0, 1, 2, 2);
    second = first | cells4(50, 51, 52, 53);
    done_cyc = 0;
    @(negedge clk);
    drive_lock(255, 0, 1, 2);
    @(posedge clk); #1 drive_lock(50, 51, 52, 53);
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (n == 2) begin
        checks++;
        if (fallen !== first) begin
          failures++; $display("FAIL hold_merge_oob got=%h want=%h", fallen, first);
        end
      end
      if (n <= 22 && lock_if.lock_ready !== 1'b0) begin
        checks++; failures++;
        $display("FAIL hold_ready_busy cycle=%0d got=1 want=0", n);
      end
      if (n == 22) begin
        checks++;
        if (fallen !== first) begin
          failures++; $display("FAIL hold_not_merged got=%h want=%h", fallen, first);
        end
      end
      if (done === 1'b1 && done_cyc == 0) done_cyc = n;
      if (n == 23) begin
        checks++;
        if (lock_if.lock_ready !== 1'b1) begin
          failures++; $display("FAIL hold_ready_c23 got=%b want=1", lock_if.lock_ready);
        end
      end
      if (n == 24) begin
        lock_if.lock_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
          failures++; $display("FAIL hold_accept busy got=%b want=1", busy);
        end
      end
      if (n == 25) begin
        checks++;
        if (fallen !== second) begin
          failures++; $display("FAIL hold_second_merge got=%h want=%h", fallen, second);
        end
      end
    end
    checks++;
    if (done_cyc != 22) begin
      failures++; $display("FAIL hold_done_cycle got=%0d want=22", done_cyc);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_lock(100, 101, 102, 103);
    @(posedge clk); #1 lock_if.lock_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (fallen !== '0 || busy !== 1'b0 || lock_if.lock_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid fp=%h busy=%b rdy=%b done=%b",
                           fallen, busy, lock_if.lock_ready, done);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    clear_board = 1'b0;
    lock_if.lock_valid = 1'b0;
    lock_if.lock_blk_1 = '0;
    lock_if.lock_blk_2 = '0;
    lock_if.lock_blk_3 = '0;
    lock_if.lock_blk_4 = '0;
    test_reset();
    test_single_lock();
    test_line_clear();
    test_tetris();
    test_clear_board();
    test_busy_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
